spi_slave_sync: RTL and testbench
=================================

Name: spi_slave_sync

Overview:
Parametrised SPI slave that runs entirely in the PCLK domain and oversamples the asynchronous SPI pins (SCK, SS, MOSI). It supports all four SPI modes, configurable word width and multi-word frames. The user side has a one-entry TX holding buffer with a valid/ready handshake and an RX output register with a valid/ready handshake. It sits between the external SPI pins and the APB-side register block.

Parameters:
WIDTH, 8, bits per SPI word (≥2)
SYNC_STAGES, 2, synchroniser flops on SCK/SS/MOSI (≥2)

Ports:
PCLK  in  1  system clock
PRESET  in  1  reset, synchronous, active-high
SCK  in  1  SPI clock, asynchronous to PCLK
SS  in  1  slave select, active-low, asynchronous
MOSI  in  1  serial data in, asynchronous
MODE  in  2  MODE[1]=CPOL, MODE[0]=CPHA; latched at frame start
MISO  out  1  serial data out
MISO_OE  out  1  pad output enable for MISO
TX_DATA  in  WIDTH  word to transmit
TX_VALID  in  1  TX_DATA valid
TX_READY  out  1  TX holding buffer empty
RX_DATA  out  WIDTH  last received word
RX_VALID  out  1  RX_DATA holds an unread word
RX_READY  in  1  consumer accepts RX_DATA
BUSY  out  1  frame in progress
RX_OVERRUN  out  1  sticky error flag
TX_UNDERRUN  out  1  sticky error flag
ERR_CLR  in  1  clears both sticky flags

Behaviour:
- Reset (PRESET=1 at a PCLK edge): FSM goes to IDLE.
  - Outputs: MISO=0, MISO_OE=0, TX_READY=1, RX_DATA=0, RX_VALID=0, BUSY=0, RX_OVERRUN=0, TX_UNDERRUN=0.
  - Synchronisers reset to SS=1, SCK=0, MOSI=0.
  - Reset mid-frame discards all state. If SS is still low after reset, the block waits for SS to go high and then low again.
- Synchronisation: pin edge to internal action latency is SYNC_STAGES+1 PCLK cycles. The SCK half-period must be ≥ SYNC_STAGES+2 PCLK cycles.
- Edge roles:
  - Leading edge: SCK rising when CPOL=0, falling when CPOL=1. The trailing edge is the opposite.
  - Sample edge: leading edge when CPHA=0, trailing edge when CPHA=1. The shift edge is the other one.
- FSM IDLE → ACTIVE on a synchronised SS falling edge. In the same cycle:
  - MODE is latched and the bit counter is set to 0.
  - CPHA=0: the TX shift register loads from the buffer.
  - CPHA=1: reload_pending is set.
- FSM ACTIVE → IDLE on a synchronised SS rising edge, from any bit position.
  - A partial word is discarded: no RX_VALID, bit counter reset to 0.
  - A loaded but unclocked TX word is discarded.
- TX load rule:
  - If the buffer is full, copy it into txreg and set TX_READY=1.
  - If the buffer is empty, load zeros and set an internal empty_load flag.
  - TX_UNDERRUN sets on the next sample edge while empty_load is set. SS rising clears empty_load without flagging.
- Shift edge (ACTIVE only): if reload_pending, perform a load and clear reload_pending; otherwise shift txreg left by one.
- Sample edge (ACTIVE only):
  - rxreg <= {rxreg[WIDTH-2:0], MOSI_sync} and the bit counter increments.
  - At count WIDTH-1: the counter wraps to 0, RX_DATA <= the completed word, RX_VALID is set, and reload_pending is set. Multi-word frames continue with no gap.
- MISO = MISO_OE ? txreg[WIDTH-1] : 0. MISO_OE = BUSY = (state==ACTIVE).
- TX handshake: the buffer is written when TX_VALID&&TX_READY.
  - If a load and a write happen in the same cycle with the buffer empty, the load takes zeros (underrun path) and the write is stored.
- RX handshake: RX_VALID clears on RX_VALID&&RX_READY.
  - If a word completes while RX_VALID=1 and RX_READY=0, RX_DATA is overwritten, RX_VALID stays 1 and RX_OVERRUN sets.
  - If it completes in the same cycle as an accept, there is no overrun and RX_VALID stays 1 with the new word.
- Sticky flags: ERR_CLR clears both; setting has priority over ERR_CLR in the same cycle.
- MODE changes while ACTIVE are ignored until the next frame.

Optional Feature:
Macro SPI_SLV_LSB_FIRST_EN.
- Defined: adds input port LSB_FIRST (1 bit), latched at SS fall.
  - When latched 1, txreg shifts right, MISO=txreg[0], and rxreg shifts in at the MSB ({MOSI_sync, rxreg[WIDTH-1:1]}).
  - When latched 0, behaviour is identical to the undefined case.
- Undefined: no LSB_FIRST port; MSB-first only.

Test Plan:
- Mode 0, WIDTH=8: TX_DATA=0xA5 preloaded; master sends 0x3C in one frame → master receives 0xA5; RX_DATA=0x3C with RX_VALID=1 exactly once; TX_READY returns to 1.
- Modes 1, 2, 3 each: preload 0x81, master sends 0x7E → master receives 0x81; RX_DATA=0x7E; no error flags.
- Mode 0 two-word frame with SS held low: preload 0x11, refill 0x22 on TX_READY; master sends 0xF0 then 0x0F → master receives 0x11, 0x22; two RX_VALID events with 0xF0 and 0x0F.
- Empty TX buffer at frame start → MISO shifts 0x00 and TX_UNDERRUN=1. With RX_READY=0, send two words → RX_DATA=second word and RX_OVERRUN=1. Pulse ERR_CLR → both flags 0.
- SS raised after 3 bits → BUSY=0 within SYNC_STAGES+2 cycles, no RX_VALID; the next full frame receives correctly. PRESET asserted mid-frame → all outputs at reset values, and no action until SS high then low.
- SPI_SLV_LSB_FIRST_EN defined, LSB_FIRST=1, mode 0: preload 0x01, master sends 0x80 with bits transmitted LSB first → master sees 1 as the first bit; RX_DATA=0x80.

Source files
------------

// File: rtl/spi_slave_sync_if.sv
// User-side handshake bundle for spi_slave_sync: TX holding buffer
// write port (TX_DATA/TX_VALID/TX_READY) and RX output port
// (RX_DATA/RX_VALID/RX_READY). Modport slave is the SPI block,
// modport master is the consumer/producer (e.g. the APB register block).
interface spi_slave_sync_if #(
   parameter int WIDTH = 8
);
   logic [WIDTH-1:0] TX_DATA;
   logic             TX_VALID;
   logic             TX_READY;
   logic [WIDTH-1:0] RX_DATA;
   logic             RX_VALID;
   logic             RX_READY;

   modport slave (
      input  TX_DATA,
      input  TX_VALID,
      input  RX_READY,
      output TX_READY,
      output RX_DATA,
      output RX_VALID
   );

   modport master (
      output TX_DATA,
      output TX_VALID,
      output RX_READY,
      input  TX_READY,
      input  RX_DATA,
      input  RX_VALID
   );
endinterface

// File: rtl/spi_slave_sync.sv
// SPI slave oversampled in the PCLK domain; all four modes, WIDTH-bit
// words, multi-word frames, one-entry TX buffer and RX output register.
// Ports: PCLK, PRESET (sync, active-high), SCK/SS/MOSI (async pins),
//   MODE {CPOL,CPHA}, MISO/MISO_OE, BUSY, RX_OVERRUN, TX_UNDERRUN,
//   ERR_CLR, user (spi_slave_sync_if.slave: TX and RX handshakes).
// Optional: `define SPI_SLV_LSB_FIRST_EN adds LSB_FIRST (latched at SS fall).
module spi_slave_sync #(
   parameter int WIDTH       = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic       PCLK,
   input  logic       PRESET,
   input  logic       SCK,
   input  logic       SS,
   input  logic       MOSI,
   input  logic [1:0] MODE,
`ifdef SPI_SLV_LSB_FIRST_EN
   input  logic       LSB_FIRST,
`endif
   output logic       MISO,
   output logic       MISO_OE,
   output logic       BUSY,
   output logic       RX_OVERRUN,
   output logic       TX_UNDERRUN,
   input  logic       ERR_CLR,
   spi_slave_sync_if.slave user
);

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic {
      IDLE,
      ACTIVE
   } state_t;

   // pin synchronisers
   logic [SYNC_STAGES-1:0] sck_sync_q;
   logic [SYNC_STAGES-1:0] ss_sync_q;
   logic [SYNC_STAGES-1:0] mosi_sync_q;
   logic                   sck_prev_q;
   logic                   ss_prev_q;
   // fills with ones after reset; the sync chain holds genuine pin
   // values only once the last bit is set
   logic [SYNC_STAGES-1:0] flush_q;
   logic                   armed_q, armed_d;

   logic sck_s, ss_s, mosi_s;
   logic sck_rise, sck_fall;
   logic ss_fall, ss_rise;
   logic lead_edge, trail_edge;
   logic sample_edge, shift_edge;

   state_t           state_q, state_d;
   logic             cpol_q, cpol_d;
   logic             cpha_q, cpha_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] txreg_q, txreg_d;
   logic [WIDTH-1:0] rxreg_q, rxreg_d;
   logic             reload_q, reload_d;
   logic             empty_q, empty_d;
   logic [WIDTH-1:0] buf_q, buf_d;
   logic             full_q, full_d;
   logic [WIDTH-1:0] rxd_q, rxd_d;
   logic             rxv_q, rxv_d;
   logic             ovr_q, ovr_d;
   logic             und_q, und_d;
   logic             lsb_mode;
   logic             do_load;
   logic [WIDTH-1:0] rx_next;

`ifdef SPI_SLV_LSB_FIRST_EN
   logic lsb_q, lsb_d;
   assign lsb_mode = lsb_q;
`else
   assign lsb_mode = 1'b0;
`endif

   assign sck_s  = sck_sync_q[SYNC_STAGES-1];
   assign ss_s   = ss_sync_q[SYNC_STAGES-1];
   assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

   assign sck_rise = sck_s & ~sck_prev_q;
   assign sck_fall = ~sck_s & sck_prev_q;
   // a fall only counts once SS has been seen high after reset
   assign ss_fall  = ss_prev_q & ~ss_s & armed_q;
   assign ss_rise  = ss_s & ~ss_prev_q;

   assign lead_edge   = cpol_q ? sck_fall : sck_rise;
   assign trail_edge  = cpol_q ? sck_rise : sck_fall;
   assign sample_edge = cpha_q ? trail_edge : lead_edge;
   assign shift_edge  = cpha_q ? lead_edge : trail_edge;

   assign armed_d = armed_q | (flush_q[SYNC_STAGES-1] & ss_s);

   assign rx_next = lsb_mode ? {mosi_s, rxreg_q[WIDTH-1:1]}
                             : {rxreg_q[WIDTH-2:0], mosi_s};

   assign BUSY        = (state_q == ACTIVE);
   assign MISO_OE     = BUSY;
   assign MISO        = BUSY & (lsb_mode ? txreg_q[0] : txreg_q[WIDTH-1]);
   assign RX_OVERRUN  = ovr_q;
   assign TX_UNDERRUN = und_q;

   assign user.TX_READY = ~full_q;
   assign user.RX_DATA  = rxd_q;
   assign user.RX_VALID = rxv_q;

   always_comb begin
      state_d  = state_q;
      cpol_d   = cpol_q;
      cpha_d   = cpha_q;
      cnt_d    = cnt_q;
      txreg_d  = txreg_q;
      rxreg_d  = rxreg_q;
      reload_d = reload_q;
      empty_d  = empty_q;
      buf_d    = buf_q;
      full_d   = full_q;
      rxd_d    = rxd_q;
      rxv_d    = rxv_q;
      ovr_d    = ovr_q;
      und_d    = und_q;
      do_load  = 1'b0;
`ifdef SPI_SLV_LSB_FIRST_EN
      lsb_d    = lsb_q;
`endif

      if (rxv_q && user.RX_READY) rxv_d = 1'b0;

      // clear first so a same-cycle set below wins
      if (ERR_CLR) begin
         ovr_d = 1'b0;
         und_d = 1'b0;
      end

      unique case (state_q)
         IDLE: begin
            if (ss_fall) begin
               state_d = ACTIVE;
               cpol_d  = MODE[1];
               cpha_d  = MODE[0];
               cnt_d   = '0;
`ifdef SPI_SLV_LSB_FIRST_EN
               lsb_d   = LSB_FIRST;
`endif
               if (MODE[0]) reload_d = 1'b1;
               else         do_load  = 1'b1;
            end
         end
         ACTIVE: begin
            if (ss_rise) begin
               state_d  = IDLE;
               cnt_d    = '0;
               reload_d = 1'b0;
               empty_d  = 1'b0;
               txreg_d  = '0;
               rxreg_d  = '0;
            end else if (shift_edge) begin
               if (reload_q) begin
                  reload_d = 1'b0;
                  do_load  = 1'b1;
               end else if (lsb_mode) begin
                  txreg_d = txreg_q >> 1;
               end else begin
                  txreg_d = txreg_q << 1;
               end
            end else if (sample_edge) begin
               if (empty_q) begin
                  und_d   = 1'b1;
                  empty_d = 1'b0;
               end
               rxreg_d = rx_next;
               if (cnt_q == LAST) begin
                  cnt_d    = '0;
                  rxd_d    = rx_next;
                  rxv_d    = 1'b1;
                  reload_d = 1'b1;
                  if (rxv_q && !user.RX_READY) ovr_d = 1'b1;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // an empty buffer loads zeros; a write in the same cycle is
      // still stored because writes only happen while empty
      if (do_load) begin
         if (full_q) begin
            txreg_d = buf_q;
            full_d  = 1'b0;
            empty_d = 1'b0;
         end else begin
            txreg_d = '0;
            empty_d = 1'b1;
         end
      end

      if (user.TX_VALID && !full_q) begin
         buf_d  = user.TX_DATA;
         full_d = 1'b1;
      end
   end

   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         sck_sync_q  <= '0;
         ss_sync_q   <= '1;
         mosi_sync_q <= '0;
         sck_prev_q  <= 1'b0;
         ss_prev_q   <= 1'b1;
         flush_q     <= '0;
         armed_q     <= 1'b0;
         state_q     <= IDLE;
         cpol_q      <= 1'b0;
         cpha_q      <= 1'b0;
         cnt_q       <= '0;
         txreg_q     <= '0;
         rxreg_q     <= '0;
         reload_q    <= 1'b0;
         empty_q     <= 1'b0;
         buf_q       <= '0;
         full_q      <= 1'b0;
         rxd_q       <= '0;
         rxv_q       <= 1'b0;
         ovr_q       <= 1'b0;
         und_q       <= 1'b0;
`ifdef SPI_SLV_LSB_FIRST_EN
         lsb_q       <= 1'b0;
`endif
      end else begin
         sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], SCK};
         ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], SS};
         mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
         sck_prev_q  <= sck_s;
         ss_prev_q   <= ss_s;
         flush_q     <= {flush_q[SYNC_STAGES-2:0], 1'b1};
         armed_q     <= armed_d;
         state_q     <= state_d;
         cpol_q      <= cpol_d;
         cpha_q      <= cpha_d;
         cnt_q       <= cnt_d;
         txreg_q     <= txreg_d;
         rxreg_q     <= rxreg_d;
         reload_q    <= reload_d;
         empty_q     <= empty_d;
         buf_q       <= buf_d;
         full_q      <= full_d;
         rxd_q       <= rxd_d;
         rxv_q       <= rxv_d;
         ovr_q       <= ovr_d;
         und_q       <= und_d;
`ifdef SPI_SLV_LSB_FIRST_EN
         lsb_q       <= lsb_d;
`endif
      end
   end

endmodule

// File: tb/tb_spi_slave_sync.sv
// Directed bench for spi_slave_sync: bit-banged SPI master, all modes,
// multi-word, underrun/overrun, abort and mid-frame reset.
module tb_spi_slave_sync;

   localparam int H = 8;

   logic       PCLK = 1'b0;
   logic       PRESET = 1'b1;
   logic       SCK = 1'b0;
   logic       SS = 1'b1;
   logic       MOSI = 1'b0;
   logic [1:0] MODE = 2'b00;
   logic       ERR_CLR = 1'b0;
   logic       LSB_FIRST = 1'b0;
   logic       MISO, MISO_OE, BUSY, RX_OVERRUN, TX_UNDERRUN;

   spi_slave_sync_if #(.WIDTH(8)) u_if ();

   spi_slave_sync #(.WIDTH(8), .SYNC_STAGES(2)) dut (
      .PCLK        (PCLK),
      .PRESET      (PRESET),
      .SCK         (SCK),
      .SS          (SS),
      .MOSI        (MOSI),
      .MODE        (MODE),
`ifdef SPI_SLV_LSB_FIRST_EN
      .LSB_FIRST   (LSB_FIRST),
`endif
      .MISO        (MISO),
      .MISO_OE     (MISO_OE),
      .BUSY        (BUSY),
      .RX_OVERRUN  (RX_OVERRUN),
      .TX_UNDERRUN (TX_UNDERRUN),
      .ERR_CLR     (ERR_CLR),
      .user        (u_if)
   );

   always #5 PCLK = ~PCLK;

   int checks = 0;
   int failures = 0;
   int rx_rises = 0;
   int acc_n = 0;
   logic [7:0] acc [0:15];
   logic rxv_prev = 1'b0;
   logic cpol_r = 1'b0;
   logic cpha_r = 1'b0;

   always @(posedge PCLK) begin
      if (u_if.RX_VALID && !rxv_prev) rx_rises++;
      if (u_if.RX_VALID && u_if.RX_READY && acc_n < 16) begin
         acc[acc_n] = u_if.RX_DATA;
         acc_n++;
      end
      rxv_prev = u_if.RX_VALID;
   end

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge PCLK);
   endtask

   task automatic set_mode(input logic [1:0] m);
      MODE = m;
      cpol_r = m[1];
      cpha_r = m[0];
      SCK = m[1];
      cycles(H);
   endtask

   task automatic preload(input logic [7:0] d);
      u_if.TX_DATA = d;
      u_if.TX_VALID = 1'b1;
      cycles(1);
      u_if.TX_VALID = 1'b0;
   endtask

   task automatic ss_on();
      SS = 1'b0;
      cycles(6);
   endtask

   task automatic ss_off();
      cycles(H);
      SS = 1'b1;
      cycles(8);
   endtask

   task automatic consume();
      u_if.RX_READY = 1'b1;
      cycles(2);
      u_if.RX_READY = 1'b0;
   endtask

   task automatic xfer(input logic [7:0] tx, input int nb, input logic lsb,
                       output logic [7:0] rx);
      logic b;
      logic got;
      rx = 8'h00;
      for (int i = 0; i < nb; i++) begin
         b = lsb ? tx[i] : tx[7-i];
         if (!cpha_r) begin
            MOSI = b;
            cycles(H);
            SCK = ~cpol_r;
            got = MISO;
            cycles(H);
            SCK = cpol_r;
         end else begin
            SCK = ~cpol_r;
            MOSI = b;
            cycles(H);
            SCK = cpol_r;
            got = MISO;
            cycles(H);
         end
         if (lsb) rx[i] = got;
         else     rx[7-i] = got;
      end
   endtask

   task automatic check_reset(input string p);
      check({p, "_miso"}, MISO, 0);
      check({p, "_oe"}, MISO_OE, 0);
      check({p, "_txrdy"}, u_if.TX_READY, 1);
      check({p, "_rxdata"}, u_if.RX_DATA, 0);
      check({p, "_rxv"}, u_if.RX_VALID, 0);
      check({p, "_busy"}, BUSY, 0);
      check({p, "_ovr"}, RX_OVERRUN, 0);
      check({p, "_und"}, TX_UNDERRUN, 0);
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] r, r2;
      int base, n;
      u_if.TX_DATA = 8'h00;
      u_if.TX_VALID = 1'b0;
      u_if.RX_READY = 1'b0;
      cycles(4);
      check_reset("rst");
      PRESET = 1'b0;
      cycles(10);
      check_reset("post_rst");

      // mode 0 single word
      set_mode(2'b00);
      preload(8'hA5);
      check("m0_txrdy_full", u_if.TX_READY, 0);
      base = rx_rises;
      ss_on();
      check("m0_busy", BUSY, 1);
      check("m0_txrdy_load", u_if.TX_READY, 1);
      xfer(8'h3C, 8, 1'b0, r);
      ss_off();
      check("m0_miso", r, 8'hA5);
      check("m0_rxdata", u_if.RX_DATA, 8'h3C);
      check("m0_rxv", u_if.RX_VALID, 1);
      check("m0_rx_once", rx_rises - base, 1);
      check("m0_busy_end", BUSY, 0);
      check("m0_und", TX_UNDERRUN, 0);
      consume();
      check("m0_rxv_clr", u_if.RX_VALID, 0);

      // modes 1..3
      for (int m = 1; m < 4; m++) begin
         set_mode(2'(m));
         preload(8'h81);
         ss_on();
         xfer(8'h7E, 8, 1'b0, r);
         ss_off();
         check($sformatf("m%0d_miso", m), r, 8'h81);
         check($sformatf("m%0d_rx", m), u_if.RX_DATA, 8'h7E);
         check($sformatf("m%0d_ovr", m), RX_OVERRUN, 0);
         check($sformatf("m%0d_und", m), TX_UNDERRUN, 0);
         consume();
      end

      // two-word frame, consumer always ready
      set_mode(2'b00);
      u_if.RX_READY = 1'b1;
      n = acc_n;
      preload(8'h11);
      ss_on();
      check("mw_txrdy", u_if.TX_READY, 1);
      preload(8'h22);
      xfer(8'hF0, 8, 1'b0, r);
      xfer(8'h0F, 8, 1'b0, r2);
      ss_off();
      check("mw_miso0", r, 8'h11);
      check("mw_miso1", r2, 8'h22);
      check("mw_nwords", acc_n - n, 2);
      check("mw_rx0", acc[n], 8'hF0);
      check("mw_rx1", acc[n+1], 8'h0F);
      check("mw_und", TX_UNDERRUN, 0);
      u_if.RX_READY = 1'b0;

      // underrun + overrun, then clear
      ss_on();
      xfer(8'h55, 8, 1'b0, r);
      xfer(8'hAA, 8, 1'b0, r2);
      ss_off();
      check("ur_miso0", r, 8'h00);
      check("ur_miso1", r2, 8'h00);
      check("ur_und", TX_UNDERRUN, 1);
      check("ur_ovr", RX_OVERRUN, 1);
      check("ur_rx", u_if.RX_DATA, 8'hAA);
      check("ur_rxv", u_if.RX_VALID, 1);
      ERR_CLR = 1'b1;
      cycles(1);
      ERR_CLR = 1'b0;
      cycles(1);
      check("clr_und", TX_UNDERRUN, 0);
      check("clr_ovr", RX_OVERRUN, 0);
      consume();

      // abort after 3 bits
      base = rx_rises;
      preload(8'h5A);
      ss_on();
      xfer(8'hFF, 3, 1'b0, r);
      cycles(H);
      SS = 1'b1;
      n = 0;
      while (BUSY && n < 20) begin
         cycles(1);
         n++;
      end
      check("ab_busy_lat", (n >= 1 && n <= 4), 1);
      cycles(8);
      check("ab_norx", rx_rises - base, 0);
      preload(8'hC3);
      ss_on();
      xfer(8'h96, 8, 1'b0, r);
      ss_off();
      check("ab_next_miso", r, 8'hC3);
      check("ab_next_rx", u_if.RX_DATA, 8'h96);
      consume();

      // reset mid-frame, SS held low
      preload(8'h3C);
      ss_on();
      xfer(8'h00, 3, 1'b0, r);
      PRESET = 1'b1;
      cycles(2);
      PRESET = 1'b0;
      cycles(1);
      check_reset("mrst");
      base = rx_rises;
      xfer(8'hFF, 8, 1'b0, r);
      check("mrst_busy", BUSY, 0);
      check("mrst_oe", MISO_OE, 0);
      check("mrst_norx", rx_rises - base, 0);
      ss_off();
      preload(8'hE7);
      ss_on();
      check("mrst_rearm", BUSY, 1);
      xfer(8'h24, 8, 1'b0, r);
      ss_off();
      check("mrst_miso", r, 8'hE7);
      check("mrst_rx", u_if.RX_DATA, 8'h24);
      consume();

`ifdef SPI_SLV_LSB_FIRST_EN
      LSB_FIRST = 1'b1;
      preload(8'h01);
      ss_on();
      xfer(8'h80, 8, 1'b1, r);
      ss_off();
      LSB_FIRST = 1'b0;
      check("lsb_first_bit", r[0], 1);
      check("lsb_miso", r, 8'h01);
      check("lsb_rx", u_if.RX_DATA, 8'h80);
      consume();
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
